// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: hazard inputs from the
// stage registers and the enable/flush/bubble/counter outputs back to them.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       ifid_rs1;
   logic [4:0]       ifid_rs2;
   logic             ifid_use_rs1;
   logic             ifid_use_rs2;
   logic [4:0]       idex_rd;
   logic             idex_memread;
   logic             idex_muldiv;
   logic             ex_branch_taken;
   logic             exmem_mem_req;
   logic             dmem_ready;
   logic             muldiv_done;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_write;
   logic             idex_flush;
   logic             exmem_write;
   logic             exmem_bubble;
   logic             memwb_bubble;
   logic             muldiv_start;
   logic             md_error;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, idex_rd,
             idex_memread, idex_muldiv, ex_branch_taken, exmem_mem_req,
             dmem_ready, muldiv_done,
      input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_bubble, memwb_bubble, muldiv_start,
             md_error, stall_cnt, flush_cnt
   );

   modport slave (
      input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, idex_rd,
             idex_memread, idex_muldiv, ex_branch_taken, exmem_mem_req,
             dmem_ready, muldiv_done,
      output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
             exmem_write, exmem_bubble, memwb_bubble, muldiv_start,
             md_error, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stalls, flushes and bubbles for
// load-use, taken branches, data-memory waits and multi-cycle MUL/DIV.
module hazard_ctrl #(
   parameter int unsigned MD_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 16
) (
   input logic         clk,
   input logic         reset_n,
   hazard_ctrl_if.slave bus
);
   localparam int unsigned MD_CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]    CNT_MAX = '1;

   typedef enum logic {ST_RUN, ST_MD_BUSY} state_t;

   state_t              r_state;
   logic [MD_CNT_W-1:0] r_md_cnt;
   logic                r_md_error;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic [CNT_W-1:0]    r_flush_cnt;

   state_t w_next_state;
   logic   w_mem_stall, w_load_use, w_md_timeout;
   logic   w_md_clr, w_md_inc, w_md_err_set, w_flush_inc;
   logic   w_pc_write, w_ifid_write, w_ifid_flush, w_idex_write, w_idex_flush;
   logic   w_exmem_write, w_exmem_bubble, w_memwb_bubble, w_muldiv_start;

   assign w_mem_stall  = bus.exmem_mem_req & ~bus.dmem_ready;
   assign w_load_use   = bus.idex_memread & (bus.idex_rd != 5'd0) &
                         ((bus.ifid_use_rs1 & (bus.ifid_rs1 == bus.idex_rd)) |
                          (bus.ifid_use_rs2 & (bus.ifid_rs2 == bus.idex_rd)));
   assign w_md_timeout = (r_md_cnt == MD_LAST);

   // Next state and stage controls; a release cycle leaves every enable at its default.
   always_comb begin
      w_pc_write     = 1'b1;
      w_ifid_write   = 1'b1;
      w_ifid_flush   = 1'b0;
      w_idex_write   = 1'b1;
      w_idex_flush   = 1'b0;
      w_exmem_write  = 1'b1;
      w_exmem_bubble = 1'b0;
      w_memwb_bubble = 1'b0;
      w_muldiv_start = 1'b0;
      w_next_state   = r_state;
      w_md_clr       = 1'b0;
      w_md_inc       = 1'b0;
      w_md_err_set   = 1'b0;
      w_flush_inc    = 1'b0;
      if (!reset_n) begin
         w_pc_write    = 1'b0;
         w_ifid_write  = 1'b0;
         w_idex_write  = 1'b0;
         w_exmem_write = 1'b0;
         w_next_state  = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_mem_stall) begin
                  w_pc_write     = 1'b0;
                  w_ifid_write   = 1'b0;
                  w_idex_write   = 1'b0;
                  w_exmem_write  = 1'b0;
                  w_memwb_bubble = 1'b1;
               end else if (bus.idex_muldiv) begin
                  w_muldiv_start = 1'b1;
                  w_pc_write     = 1'b0;
                  w_ifid_write   = 1'b0;
                  w_idex_write   = 1'b0;
                  w_exmem_bubble = 1'b1;
                  w_next_state   = ST_MD_BUSY;
                  w_md_clr       = 1'b1;
               end else if (bus.ex_branch_taken) begin
                  w_ifid_flush = 1'b1;
                  w_idex_flush = 1'b1;
                  w_flush_inc  = 1'b1;
               end else if (w_load_use) begin
                  w_pc_write   = 1'b0;
                  w_ifid_write = 1'b0;
                  w_idex_flush = 1'b1;
               end
            end
            ST_MD_BUSY: begin
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b0;
               w_idex_write = 1'b0;
               if (w_mem_stall) begin
                  w_exmem_write  = 1'b0;
                  w_memwb_bubble = 1'b1;
                  w_md_inc       = ~w_md_timeout;
               end else if (bus.muldiv_done || w_md_timeout) begin
                  w_pc_write   = 1'b1;
                  w_ifid_write = 1'b1;
                  w_idex_write = 1'b1;
                  w_next_state = ST_RUN;
                  w_md_err_set = ~bus.muldiv_done;
               end else begin
                  w_exmem_bubble = 1'b1;
                  w_md_inc       = 1'b1;
               end
            end
            default: w_next_state = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_RUN;
         r_md_cnt    <= '0;
         r_md_error  <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_md_clr)
            r_md_cnt <= '0;
         else if (w_md_inc)
            r_md_cnt <= r_md_cnt + MD_CNT_W'(1);
         if (w_md_err_set)
            r_md_error <= 1'b1;
         // Performance counters saturate instead of wrapping.
         if (!w_pc_write && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_inc && (r_flush_cnt != CNT_MAX))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign bus.pc_write     = w_pc_write;
   assign bus.ifid_write   = w_ifid_write;
   assign bus.ifid_flush   = w_ifid_flush;
   assign bus.idex_write   = w_idex_write;
   assign bus.idex_flush   = w_idex_flush;
   assign bus.exmem_write  = w_exmem_write;
   assign bus.exmem_bubble = w_exmem_bubble;
   assign bus.memwb_bubble = w_memwb_bubble;
   assign bus.muldiv_start = w_muldiv_start;
   assign bus.md_error     = r_md_error;
   assign bus.stall_cnt    = r_stall_cnt;
   assign bus.flush_cnt    = r_flush_cnt;
endmodule
